// File: rtl/st_pkg.sv
// Store-path shared types: request/beat bundles and lane alignment helpers.
// Imported by the FIFO and the store data controller.
package st_pkg;

   localparam logic [2:0] SZ_B = 3'b001;
   localparam logic [2:0] SZ_H = 3'b010;
   localparam logic [2:0] SZ_W = 3'b011;

   typedef enum logic [1:0] {
      IDLE,
      BEAT0,
      BEAT1
   } st_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
   } st_req_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  web;
   } dm_beat_t;

   function automatic logic is_split(st_req_t r);
      return (r.size == SZ_H[1:0] && r.addr[1:0] == 2'b11) ||
             (r.size == SZ_W[1:0] && r.addr[1:0] != 2'b00);
   endfunction

   // Shift the sized data into a 64-bit two-word window; hi picks word 2.
   function automatic dm_beat_t align(st_req_t r, logic hi);
      logic [31:0] d;
      logic [3:0]  m;
      logic [63:0] sh;
      logic [7:0]  en;
      logic [31:0] base;
      dm_beat_t    b;
      case (r.size)
         2'b01: begin
            d = {24'h0, r.data[7:0]};
            m = 4'b0001;
         end
         2'b10: begin
            d = {16'h0, r.data[15:0]};
            m = 4'b0011;
         end
         default: begin
            d = r.data;
            m = 4'b1111;
         end
      endcase
      sh = {32'h0, d} << {r.addr[1:0], 3'b000};
      en = {4'h0, m} << r.addr[1:0];
      base = {r.addr[31:2], 2'b00};
      b.addr = hi ? base + 32'd4 : base;
      b.wdata = hi ? sh[63:32] : sh[31:0];
      b.web = hi ? ~en[7:4] : ~en[3:0];
      return b;
   endfunction

endpackage

// File: rtl/st_fifo.sv
// Store request FIFO; exposes the head and the entry behind it so the
// sequencer can chain beats without a bubble.
module st_fifo
   import st_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  logic    push,
   input  logic    pop,
   input  st_req_t din,
   output st_req_t head,
   output st_req_t nxt,
   output logic    full,
   output logic    empty,
   output logic    multi
);

   localparam int AW = $clog2(DEPTH);

   st_req_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push}
                        - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign nxt   = mem[rd_ptr + 1'b1];
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign multi = count > (AW+1)'(1);

endmodule

// File: rtl/st_data_ctlr.sv
// Store data controller: queues SB/SH/SW and issues lane-aligned,
// word-aligned data-memory beats, splitting misaligned stores in two.
module st_data_ctlr
   import st_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_st_valid,
   output logic        o_st_ready,
   input  logic [31:0] i_st_addr,
   input  logic [31:0] i_st_data,
   input  logic [2:0]  i_DM_write,
   output logic        o_st_err,
   output logic        o_dm_valid,
   input  logic        i_dm_ready,
   output logic [31:0] o_dm_addr,
   output logic [31:0] o_dm_wdata,
   output logic [3:0]  o_dm_web,
   output logic        o_st_pending
);

   st_state_t state;
   dm_beat_t  beat;
   st_req_t   din;
   st_req_t   head;
   st_req_t   nxt;
   logic      full;
   logic      empty;
   logic      multi;
   logic      legal;
   logic      push;
   logic      pop;
   logic      hs;
   logic      last;
   dm_beat_t  b0;
   dm_beat_t  b1;
   dm_beat_t  n0;

   assign legal = i_DM_write == SZ_B ||
                  i_DM_write == SZ_H ||
                  i_DM_write == SZ_W;
   assign o_st_ready = !full;
   assign push = i_st_valid && !full && legal;
   assign din = '{addr: i_st_addr,
                  data: i_st_data,
                  size: i_DM_write[1:0]};

   st_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (push),
      .pop     (pop),
      .din     (din),
      .head    (head),
      .nxt     (nxt),
      .full    (full),
      .empty   (empty),
      .multi   (multi)
   );

   assign b0 = align(head, 1'b0);
   assign b1 = align(head, 1'b1);
   assign n0 = align(nxt, 1'b0);

   assign hs   = o_dm_valid && i_dm_ready;
   assign last = (state == BEAT1) ||
                 (state == BEAT0 && !is_split(head));
   assign pop  = hs && last;

   // The head stays queued until its final beat, so the next entry is
   // read from behind it to keep back-to-back beats bubble-free.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         o_dm_valid <= 1'b0;
         beat       <= '{addr: '0, wdata: '0, web: 4'hF};
         o_st_err   <= 1'b0;
      end else begin
         o_st_err <= i_st_valid && !full && !legal;
         unique case (state)
            IDLE: begin
               if (!empty) begin
                  beat       <= b0;
                  o_dm_valid <= 1'b1;
                  state      <= BEAT0;
               end
            end
            BEAT0, BEAT1: begin
               if (hs) begin
                  if (!last) begin
                     beat  <= b1;
                     state <= BEAT1;
                  end else if (multi) begin
                     beat  <= n0;
                     state <= BEAT0;
                  end else begin
                     o_dm_valid <= 1'b0;
                     beat.web   <= 4'hF;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_dm_addr    = beat.addr;
   assign o_dm_wdata   = beat.wdata;
   assign o_dm_web     = beat.web;
   assign o_st_pending = !empty || state != IDLE;

endmodule

// File: tb/tb_st_data_ctlr.sv
// Directed bench for st_data_ctlr with a byte-level reference model
// checking every memory beat against the expected store stream.
module tb_st_data_ctlr;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic [2:0]  dm_write = '0;
   logic        st_err;
   logic        dm_valid;
   logic        dm_ready = 1'b1;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_web;
   logic        st_pending;

   always #5 clk = ~clk;

   st_data_ctlr #(.DEPTH(2)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_st_valid   (st_valid),
      .o_st_ready   (st_ready),
      .i_st_addr    (st_addr),
      .i_st_data    (st_data),
      .i_DM_write   (dm_write),
      .o_st_err     (st_err),
      .o_dm_valid   (dm_valid),
      .i_dm_ready   (dm_ready),
      .o_dm_addr    (dm_addr),
      .o_dm_wdata   (dm_wdata),
      .o_dm_web     (dm_web),
      .o_st_pending (st_pending)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  w;
   } bt_t;

   bt_t expq[$];
   bt_t logq[$];
   int  tests = 0;
   int  fails = 0;
   logic prev_stall = 1'b0;
   bt_t  prev;

   task automatic chk(string nm, logic [127:0] act,
                      logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic log_chk(string nm, int i, bt_t e);
      tests++;
      if (i >= logq.size()) begin
         fails++;
         $display("FAIL %s act=missing exp=%0h", nm, e);
      end else if (logq[i] !== e) begin
         fails++;
         $display("FAIL %s act=%0h exp=%0h", nm, logq[i], e);
      end
   endtask

   // Walk the store byte by byte; a new beat opens whenever the
   // byte address crosses into another word.
   function automatic void model_push(logic [31:0] a,
                                      logic [31:0] d,
                                      logic [2:0] sz);
      int   n;
      int   lane;
      bt_t  cur;
      logic have;
      logic [31:0] ba;
      n = (sz == 3'd1) ? 1 : (sz == 3'd2) ? 2 : 4;
      have = 1'b0;
      cur = '0;
      for (int k = 0; k < n; k++) begin
         ba = a + k;
         if (!have || cur.a != {ba[31:2], 2'b00}) begin
            if (have) expq.push_back(cur);
            cur.a = {ba[31:2], 2'b00};
            cur.d = '0;
            cur.w = 4'hF;
            have = 1'b1;
         end
         lane = int'(ba[1:0]);
         cur.d[lane*8 +: 8] = d[k*8 +: 8];
         cur.w[lane] = 1'b0;
      end
      expq.push_back(cur);
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall)
            chk("hold", {dm_valid, dm_addr, dm_wdata, dm_web},
                {1'b1, prev});
         if (dm_valid && dm_ready) begin
            if (expq.size() == 0) begin
               chk("extra_beat", {dm_addr, dm_wdata, dm_web}, '1);
            end else begin
               chk("beat", {dm_addr, dm_wdata, dm_web},
                   expq.pop_front());
            end
            logq.push_back({dm_addr, dm_wdata, dm_web});
         end
         prev_stall = dm_valid && !dm_ready;
         prev = {dm_addr, dm_wdata, dm_web};
         if (st_valid && st_ready &&
             dm_write inside {3'd1, 3'd2, 3'd3})
            model_push(st_addr, st_data, dm_write);
      end else begin
         prev_stall = 1'b0;
         expq.delete();
      end
   end

   task automatic send(logic [31:0] a, logic [31:0] d,
                       logic [2:0] sz);
      int t;
      @(posedge clk); #1;
      st_valid = 1'b1;
      st_addr = a;
      st_data = d;
      dm_write = sz;
      t = 0;
      while (!st_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!st_ready) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      st_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (st_pending && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      @(negedge clk);
      chk("drain_pending", st_pending, 0);
      chk("drain_model", expq.size(), 0);
   endtask

   initial begin
      int nv;
      #12;
      chk("rst_valid", dm_valid, 0);
      chk("rst_web", dm_web, 4'hF);
      chk("rst_addr", dm_addr, 0);
      chk("rst_wdata", dm_wdata, 0);
      chk("rst_err", st_err, 0);
      chk("rst_pending", st_pending, 0);
      chk("rst_ready", st_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      logq.delete();
      send(32'h102, 32'hAB, 3'd1);
      chk("sb_pending", st_pending, 1);
      drain();
      log_chk("sb_beat", 0, {32'h100, 32'h00AB_0000, 4'b1011});

      logq.delete();
      send(32'h203, 32'h1234, 3'd2);
      drain();
      log_chk("sh_b0", 0, {32'h200, 32'h3400_0000, 4'b0111});
      log_chk("sh_b1", 1, {32'h204, 32'h0000_0012, 4'b1110});

      logq.delete();
      send(32'hFFFF_FFFE, 32'hDEAD_BEEF, 3'd3);
      drain();
      log_chk("sw_b0", 0,
              {32'hFFFF_FFFC, 32'hBEEF_0000, 4'b0011});
      log_chk("sw_b1", 1, {32'h0, 32'h0000_DEAD, 4'b1100});

      logq.delete();
      send(32'h501, 32'hA1B2_C3D4, 3'd3);
      send(32'h600, 32'h0000_0077, 3'd1);
      send(32'h612, 32'h0000_9988, 3'd2);
      drain();
      log_chk("sw1_b0", 0, {32'h500, 32'hB2C3_D400, 4'b0001});
      log_chk("sw1_b1", 1, {32'h504, 32'h0000_00A1, 4'b1110});
      log_chk("sh2_b0", 3, {32'h610, 32'h9988_0000, 4'b0011});

      logq.delete();
      dm_ready = 1'b0;
      send(32'h300, 32'h1122_3344, 3'd3);
      send(32'h305, 32'h0000_0055, 3'd1);
      chk("full_ready", st_ready, 0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("full_hold_ready", st_ready, 0);
      dm_ready = 1'b1;
      @(negedge clk);
      chk("drain_v0", dm_valid, 1);
      chk("drain_full_no_bypass", st_ready, 0);
      @(negedge clk);
      chk("drain_v1", dm_valid, 1);
      @(negedge clk);
      chk("drain_done", st_pending, 0);
      log_chk("order_a", 0, {32'h300, 32'h1122_3344, 4'b0000});
      log_chk("order_b", 1, {32'h304, 32'h0000_5500, 4'b1101});

      logq.delete();
      send(32'h700, 32'h1234_5678, 3'b111);
      chk("err_pulse", st_err, 1);
      chk("err_pending", st_pending, 0);
      @(posedge clk); #1;
      chk("err_clear", st_err, 0);
      chk("err_no_beat", dm_valid, 0);
      chk("err_no_log", logq.size(), 0);

      dm_ready = 1'b0;
      send(32'h401, 32'hDEAD_BEEF, 3'd3);
      nv = 0;
      while (!dm_valid && nv < 20) begin
         @(posedge clk); #1;
         nv++;
      end
      chk("mid_valid", dm_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", dm_valid, 0);
      chk("mid_rst_web", dm_web, 4'hF);
      @(negedge clk);
      rst_n = 1'b1;
      dm_ready = 1'b1;
      nv = 0;
      repeat (6) begin
         @(negedge clk);
         if (dm_valid) nv++;
      end
      chk("post_rst_beats", nv, 0);
      chk("post_rst_pending", st_pending, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
